// File: rtl/mult_div_unit.sv
// Iterative HI/LO multiply/divide unit for the EX stage: 33-cycle radix-2 MULT/MULTU/DIV/DIVU,
// single-cycle MTHI/MTLO, and a stall request for the hazard logic while busy.
module mult_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] oper1,
    input  logic [WIDTH-1:0] oper2,
    input  logic             rd_req,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]           state;
    logic [CNT_W-1:0]     cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [WIDTH-1:0]     mag_b;
    logic [WIDTH-1:0]     orig_a;
    logic                 sign_a, sign_b;
    logic                 is_div, is_signed;

    logic                 in_signed;
    logic [WIDTH-1:0]     abs1, abs2;
    logic [WIDTH:0]       sum, rem, diff;
    logic                 qbit;
    logic [2*WIDTH-1:0]   acc_nxt;
    logic [WIDTH-1:0]     fix_hi, fix_lo;

    assign busy  = (state != S_IDLE);
    assign stall = busy & (start | rd_req);

    always_comb begin
        in_signed = ~op[0];
        abs1 = (in_signed && oper1[WIDTH-1]) ? -oper1 : oper1;
        abs2 = (in_signed && oper2[WIDTH-1]) ? -oper2 : oper2;
    end

    // Multiply: LSB of acc selects an add into the upper half, then shift right.
    // Divide: restoring step on {remainder, next dividend bit}, quotient bit shifts in at LSB.
    always_comb begin
        sum     = '0;
        rem     = '0;
        diff    = '0;
        qbit    = 1'b0;
        acc_nxt = acc;
        if (!is_div) begin
            sum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
            acc_nxt = {sum, acc[WIDTH-1:1]};
        end else begin
            rem = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
            if (rem >= {1'b0, mag_b}) begin
                diff = rem - {1'b0, mag_b};
                qbit = 1'b1;
            end else begin
                diff = rem;
            end
            acc_nxt = {diff[WIDTH-1:0], acc[WIDTH-2:0], qbit};
        end
    end

    always_comb begin
        fix_hi = acc[2*WIDTH-1:WIDTH];
        fix_lo = acc[WIDTH-1:0];
        if (!is_div) begin
            if (is_signed && (sign_a ^ sign_b))
                {fix_hi, fix_lo} = -acc;
        end else if (mag_b == '0) begin
            fix_hi = orig_a;
            fix_lo = '1;
        end else if (is_signed) begin
            if (sign_a ^ sign_b)
                fix_lo = -acc[WIDTH-1:0];
            if (sign_a)
                fix_hi = -acc[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            cnt       <= '0;
            acc       <= '0;
            mag_b     <= '0;
            orig_a    <= '0;
            sign_a    <= 1'b0;
            sign_b    <= 1'b0;
            is_div    <= 1'b0;
            is_signed <= 1'b0;
            done      <= 1'b0;
            hi        <= '0;
            lo        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (!op[2]) begin
                            acc       <= {{WIDTH{1'b0}}, abs1};
                            mag_b     <= abs2;
                            orig_a    <= oper1;
                            sign_a    <= in_signed & oper1[WIDTH-1];
                            sign_b    <= in_signed & oper2[WIDTH-1];
                            is_div    <= op[1];
                            is_signed <= in_signed;
                            cnt       <= '0;
                            state     <= S_CALC;
                        end else if (op == 3'b100) begin
                            hi <= oper1;
                        end else if (op == 3'b101) begin
                            lo <= oper1;
                        end
                    end
                end
                S_CALC: begin
                    acc <= acc_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH - 1))
                        state <= S_FIX;
                end
                S_FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    done  <= 1'b1;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative HI/LO multiply/divide unit in the EX stage, beside the ALU; fed from the ID/EX pipeline register with the same operand pair the ALU receives.
- Executes MULT, MULTU, DIV, DIVU as 33-cycle radix-2 operations, plus single-cycle MTHI/MTLO writes. Holds the architectural HI/LO registers, which MFHI/MFLO read.
- Drives a stall request to the hazard logic so younger instructions and HI/LO readers wait while an operation is in flight.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- CNT_W, 5, iteration counter width; must satisfy 2**CNT_W == WIDTH.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  request valid this cycle; sampled on rising clk.
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 no-op.
- oper1  in  WIDTH  rs value (multiplicand/dividend; source for MTHI/MTLO).
- oper2  in  WIDTH  rt value (multiplier/divisor).
- rd_req  in  1  an MFHI/MFLO is in EX this cycle.
- busy  out  1  iterative operation in flight.
- stall  out  1  combinational: busy & (start | rd_req).
- done  out  1  one-cycle pulse when HI/LO are updated by a mult/div.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
Reset (rst_n low, any time, including mid-operation):
- Operation aborts; FSM goes to IDLE.
- hi = 0, lo = 0, busy = 0, done = 0.
- Internal accumulator and counter cleared.

FSM states: IDLE, CALC, FIX.

IDLE:
- start with op 000–011: latch operand magnitudes, both sign bits and the op. Signed ops (MULT/DIV) take the absolute value; unsigned ops take the raw value. Clear the counter and go to CALC. busy rises after this edge.
- start with op 100: hi <= oper1 at that edge. No busy, no done.
- start with op 101: lo <= oper1 at that edge. No busy, no done.
- op 110/111: ignored.

CALC:
- One shift-add (multiply) or restoring shift-subtract (divide) step per cycle; 2*WIDTH-bit working register.
- Counter increments 0..WIDTH-1; on the edge where the counter equals WIDTH-1, go to FIX.
- start is ignored (not queued) while busy. Upstream holds the instruction because stall is high.

FIX:
- Multiply: product = working register. For MULT, negate the full 2*WIDTH-bit product if the sign bits differ. {hi, lo} <= product.
- Divide: lo <= quotient, hi <= remainder. For DIV, the quotient is negated if the sign bits differ, and the remainder takes the dividend's sign.
- Divide by zero (divisor magnitude 0), same latency: lo <= all ones, hi <= original oper1. No sign fix is applied.
- DIV of 32'h8000_0000 by -1: lo = 32'h8000_0000, hi = 0 (natural wrap; no trap).
- On this edge: busy falls, done = 1 for exactly the next cycle, return to IDLE.

Latency:
- start accepted at edge E0; busy high from E0 through E33; hi/lo valid and done high after E33.
- Total: 33 cycles of busy.
- Back-to-back: a start presented in the done cycle is accepted (state is IDLE).

Stall:
- rd_req while busy raises stall; MFHI/MFLO read hi/lo only once busy is low.
- rd_req in the done cycle sees the new values (no stall).
- MTHI/MTLO with busy high: ignored, stall high until idle.

Simultaneous events:
- rst_n low overrides everything.
- FIX write and an MTHI/MTLO cannot coincide, because starts are ignored while busy.

Test Plan:
- MULTU: oper1 = 32'hFFFF_FFFF, oper2 = 32'hFFFF_FFFF -> after 33 busy cycles: hi = 32'hFFFF_FFFE, lo = 32'h0000_0001, done pulses once.
- MULT: oper1 = -3, oper2 = 7 -> hi = 32'hFFFF_FFFF, lo = 32'hFFFF_FFEB. DIV: oper1 = -7, oper2 = 2 -> lo = 32'hFFFF_FFFD, hi = 32'hFFFF_FFFF.
- DIVU by zero: oper1 = 32'h1234_5678, oper2 = 0 -> lo = 32'hFFFF_FFFF, hi = 32'h1234_5678, latency still 33.
- Hazard: start DIVU 100/7, assert rd_req on cycles 1..40 -> stall high exactly while busy (33 cycles). hi = 2, lo = 14 visible in the done cycle. A second start during busy leaves the result unchanged.
- MTHI 32'hA5A5_A5A5 then MTLO 32'h5A5A_5A5A while idle -> hi/lo update on the next edge, busy and done stay 0. A MTLO sent mid-operation does not alter lo.
- Reset mid-operation: assert rst_n = 0 at iteration 10 of MULTU -> busy, done, hi, lo all 0 immediately (asynchronous). A new MULTU 6*7 after release gives lo = 42, hi = 0 with full latency.
